// File: rtl/sosanh_cmp.sv
// rtl/sosanh_cmp.sv - registered MSB-first magnitude comparator with greater/equal/less flags
module sosanh_cmp #(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic             x,
    output logic             y,
    output logic             z
);

    logic [WIDTH-1:0] a_k;
    logic [WIDTH-1:0] b_k;
    logic             found;
    logic             a_gt;

    // Flipping both MSBs maps two's-complement ordering onto unsigned ordering.
    always_comb begin
        a_k = a;
        b_k = b;
        a_k[WIDTH-1] = a[WIDTH-1] ^ SIGNED;
        b_k[WIDTH-1] = b[WIDTH-1] ^ SIGNED;
    end

    // The first differing bit from the top decides; that bit of A set means A > B.
    always_comb begin
        found = 1'b0;
        a_gt  = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && (a_k[i] != b_k[i])) begin
                found = 1'b1;
                a_gt  = a_k[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            x         <= 1'b0;
            y         <= 1'b0;
            z         <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                x <= found && a_gt;
                y <= !found;
                z <= found && !a_gt;
            end
        end
    end

endmodule

// File: tb/tb_sosanh_cmp.sv
// tb/tb_sosanh_cmp.sv - scoreboard bench for unsigned and signed instances of sosanh_cmp
module tb_sosanh_cmp;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       ov_u, x_u, y_u, z_u;
    logic       ov_s, x_s, y_s, z_s;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [3:0] u;
        logic [3:0] s;
    } exp_t;

    exp_t       q[$];
    logic [2:0] hold_u;
    logic [2:0] hold_s;
    logic       captured;

    always #5 clk = ~clk;

    sosanh_cmp #(.WIDTH(4), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(ov_u), .x(x_u), .y(y_u), .z(z_u)
    );

    sosanh_cmp #(.WIDTH(4), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(ov_s), .x(x_s), .y(y_s), .z(z_s)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hold_u   = 3'b000;
        hold_s   = 3'b000;
        captured = 1'b0;
        q.delete();
    endtask

    // Called just after a falling edge; drives one cycle and checks the result one edge later.
    task automatic step(input string tag, input logic iv, input logic [3:0] ia, input logic [3:0] ib);
        exp_t e;
        in_valid = iv;
        a = ia;
        b = ib;
        if (iv) begin
            hold_u = {ia > ib, ia == ib, ia < ib};
            hold_s = {$signed(ia) > $signed(ib), ia == ib, $signed(ia) < $signed(ib)};
            captured = 1'b1;
        end
        e.u = {iv, hold_u};
        e.s = {iv, hold_s};
        q.push_back(e);
        @(posedge clk);
        #1;
        n_cmp++;
        assert (q.size() != 0) else begin
            n_bad++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end
        if (q.size() != 0) begin
            e = q.pop_front();
            chk({tag, "_u"}, {ov_u, x_u, y_u, z_u}, e.u);
            chk({tag, "_s"}, {ov_s, x_s, y_s, z_s}, e.s);
            if (captured)
                chk({tag, "_onehot"}, {3'b000, $onehot({x_u, y_u, z_u})}, 4'b0001);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        a = 4'd5;
        b = 4'd1;
        model_reset();
        #2;
        chk("reset_async_u", {ov_u, x_u, y_u, z_u}, 4'b0000);
        @(posedge clk);
        #1;
        chk("reset_held_u", {ov_u, x_u, y_u, z_u}, 4'b0000);
        chk("reset_held_s", {ov_s, x_s, y_s, z_s}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        step("rel_5_1", 1'b1, 4'd5, 4'd1);
        step("d_0_0", 1'b1, 4'd0, 4'd0);
        step("d_5_1", 1'b1, 4'd5, 4'd1);
        step("d_2_5", 1'b1, 4'd2, 4'd5);
        step("d_8_8", 1'b1, 4'd8, 4'd8);

        step("h_cap", 1'b1, 4'd5, 4'd1);
        for (int i = 0; i < 3; i++) step("hold", 1'b0, 4'd2, 4'd5);
        step("hold_x", 1'b0, 4'bxxxx, 4'bxxxx);

        step("e_15_0", 1'b1, 4'd15, 4'd0);
        step("e_0_15", 1'b1, 4'd0, 4'd15);
        step("e_15_15", 1'b1, 4'd15, 4'd15);
        step("s_8_7", 1'b1, 4'd8, 4'd7);
        step("s_7_8", 1'b1, 4'd7, 4'd8);
        step("s_15_14", 1'b1, 4'd15, 4'd14);

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                step("sweep", 1'b1, 4'(i), 4'(j));

        // Reset asserted between edges with in_valid high: clears at once, pending capture dropped.
        in_valid = 1'b1;
        a = 4'd9;
        b = 4'd3;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_u", {ov_u, x_u, y_u, z_u}, 4'b0000);
        chk("mid_rst_s", {ov_s, x_s, y_s, z_s}, 4'b0000);
        @(posedge clk);
        #1;
        chk("mid_rst_edge_u", {ov_u, x_u, y_u, z_u}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step("resume_idle", 1'b0, 4'd9, 4'd3);
        step("resume_3_9", 1'b1, 4'd3, 4'd9);
        step("resume_9_9", 1'b1, 4'd9, 4'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
